// File: rtl/sound_cue_sequencer.sv
// rtl/sound_cue_sequencer.sv - queues sound cues and issues ROM clip requests to the player
module sound_cue_sequencer #(
    parameter int ADDR_W       = 18,
    parameter int QDEPTH       = 4,
    parameter int WIN_START    = 0,
    parameter int WIN_END      = 16395,
    parameter int MOO_START    = 16396,
    parameter int MOO_END      = 66982,
    parameter int DETECT_START = 66983,
    parameter int DETECT_END   = 83254,
    parameter int CHEER_START  = 83255,
    parameter int CHEER_END    = 137138
) (
    input  logic                        CLOCK_50,
    input  logic                        reset,
    input  logic                        cue_valid,
    input  logic [1:0]                  cue_id,
    output logic                        cue_ready,
    input  logic                        cue_flush,
    output logic                        play_req,
    output logic [ADDR_W-1:0]           play_start,
    output logic [ADDR_W-1:0]           play_end,
    input  logic                        play_ack,
    input  logic                        play_done,
    output logic                        busy,
    output logic [$clog2(QDEPTH):0]     queue_count,
    output logic                        overflow
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_PLAY = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [1:0]        mem_q [QDEPTH];
    logic [1:0]        mem_d [QDEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              req_q, req_d;
    logic [ADDR_W-1:0] start_q, start_d;
    logic [ADDR_W-1:0] end_q, end_d;

    logic          full, empty, accept, coalesce, push, pop;
    logic [PW-1:0] tail_idx;
    logic [1:0]    head_id;

    function automatic logic [ADDR_W-1:0] clip_first(input logic [1:0] id);
        case (id)
            2'd0:    return ADDR_W'(WIN_START);
            2'd1:    return ADDR_W'(MOO_START);
            2'd2:    return ADDR_W'(DETECT_START);
            default: return ADDR_W'(CHEER_START);
        endcase
    endfunction

    function automatic logic [ADDR_W-1:0] clip_last(input logic [1:0] id);
        case (id)
            2'd0:    return ADDR_W'(WIN_END);
            2'd1:    return ADDR_W'(MOO_END);
            2'd2:    return ADDR_W'(DETECT_END);
            default: return ADDR_W'(CHEER_END);
        endcase
    endfunction

    assign full      = (count_q == CW'(QDEPTH));
    assign empty     = (count_q == '0);
    assign cue_ready = !full && !cue_flush;
    assign accept    = cue_valid && cue_ready;
    assign tail_idx  = wr_ptr_q - PW'(1);
    assign head_id   = mem_q[rd_ptr_q];
    // A repeat of the newest still-queued cue adds nothing, so it is consumed without a push.
    assign coalesce  = !empty && (cue_id == mem_q[tail_idx]);
    assign push      = accept && !coalesce;
    assign pop       = (state_q == ST_IDLE) && !empty && !cue_flush;

    // Cue FIFO pointers, occupancy and sticky overflow; flush wins over push/pop.
    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (cue_flush) begin
            rd_ptr_d   = wr_ptr_q;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (cue_valid && !cue_ready) begin
                overflow_d = 1'b1;
            end
            if (push) begin
                mem_d[wr_ptr_q] = cue_id;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Playback handshake FSM; start/end hold their last values outside REQ.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        start_d = start_q;
        end_d   = end_q;
        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    start_d = clip_first(head_id);
                    end_d   = clip_last(head_id);
                    req_d   = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (cue_flush) begin
                    req_d   = 1'b0;
                    state_d = ST_IDLE;
                end else if (play_ack) begin
                    req_d   = 1'b0;
                    state_d = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (play_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with asynchronous reset.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            req_q      <= 1'b0;
            start_q    <= '0;
            end_q      <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                mem_q[i] <= 2'd0;
            end
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            req_q      <= req_d;
            start_q    <= start_d;
            end_q      <= end_d;
            mem_q      <= mem_d;
        end
    end

    assign play_req    = req_q;
    assign play_start  = start_q;
    assign play_end    = end_q;
    assign queue_count = count_q;
    assign overflow    = overflow_q;
    assign busy        = (state_q != ST_IDLE) || !empty;
endmodule

// File: tb/tb_sound_cue_sequencer.sv
// tb/tb_sound_cue_sequencer.sv - vector-table bench for sound_cue_sequencer
module tb_sound_cue_sequencer;
    logic        clk;
    logic        reset;
    logic        cue_valid;
    logic [1:0]  cue_id;
    logic        cue_ready;
    logic        cue_flush;
    logic        play_req;
    logic [17:0] play_start;
    logic [17:0] play_end;
    logic        play_ack;
    logic        play_done;
    logic        busy;
    logic [2:0]  queue_count;
    logic        overflow;

    int n_total  = 0;
    int n_passed = 0;

    sound_cue_sequencer dut (
        .CLOCK_50    (clk),
        .reset       (reset),
        .cue_valid   (cue_valid),
        .cue_id      (cue_id),
        .cue_ready   (cue_ready),
        .cue_flush   (cue_flush),
        .play_req    (play_req),
        .play_start  (play_start),
        .play_end    (play_end),
        .play_ack    (play_ack),
        .play_done   (play_done),
        .busy        (busy),
        .queue_count (queue_count),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [1:0]  id;
        logic        flush;
        logic        ack;
        logic        done;
        logic        ready_pre;
        logic        req;
        logic [17:0] st;
        logic [17:0] en;
        logic [2:0]  cnt;
        logic        bsy;
        logic        ovf;
    } vec_t;

    vec_t vecs[$];

    localparam logic [17:0] W_S = 18'd0,     W_E = 18'd16395;
    localparam logic [17:0] M_S = 18'd16396, M_E = 18'd66982;
    localparam logic [17:0] D_S = 18'd66983, D_E = 18'd83254;
    localparam logic [17:0] C_S = 18'd83255, C_E = 18'd137138;

    function automatic void add(input logic v, input logic [1:0] id, input logic fl,
                                input logic ak, input logic dn, input logic rdy,
                                input logic rq, input logic [17:0] st, input logic [17:0] en,
                                input logic [2:0] cnt, input logic bsy, input logic ovf);
        vec_t t;
        t.valid = v;   t.id = id;   t.flush = fl; t.ack = ak; t.done = dn;
        t.ready_pre = rdy; t.req = rq; t.st = st; t.en = en;
        t.cnt = cnt; t.bsy = bsy; t.ovf = ovf;
        vecs.push_back(t);
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_passed++;
        else $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_req"},   0, 32'(play_req), 0);
        check({tag, "_start"}, 0, 32'(play_start), 0);
        check({tag, "_end"},   0, 32'(play_end), 0);
        check({tag, "_count"}, 0, 32'(queue_count), 0);
        check({tag, "_busy"},  0, 32'(busy), 0);
        check({tag, "_ovf"},   0, 32'(overflow), 0);
        check({tag, "_ready"}, 0, 32'(cue_ready), 1);
    endtask

    task automatic idle_inputs();
        cue_valid = 1'b0; cue_id = 2'd0; cue_flush = 1'b0;
        play_ack = 1'b0;  play_done = 1'b0;
    endtask

    initial begin
        // v  id fl ak dn rdy  req  start end  cnt busy ovf
        add(1, 1, 0, 0, 0, 1,  0, 18'd0, 18'd0, 1, 1, 0);   // cue moo into empty queue
        add(0, 0, 0, 0, 0, 1,  1, M_S, M_E, 0, 1, 0);       // pop, request
        add(0, 0, 0, 0, 0, 1,  1, M_S, M_E, 0, 1, 0);
        add(0, 0, 0, 1, 0, 1,  0, M_S, M_E, 0, 1, 0);       // ack -> PLAY
        add(1, 0, 0, 0, 0, 1,  0, M_S, M_E, 1, 1, 0);       // 0,0,3,2 during PLAY
        add(1, 0, 0, 0, 0, 1,  0, M_S, M_E, 1, 1, 0);       // coalesced
        add(1, 3, 0, 0, 0, 1,  0, M_S, M_E, 2, 1, 0);
        add(1, 2, 0, 0, 0, 1,  0, M_S, M_E, 3, 1, 0);
        add(0, 0, 0, 0, 1, 1,  0, M_S, M_E, 3, 1, 0);       // done
        add(0, 0, 0, 0, 0, 1,  1, W_S, W_E, 2, 1, 0);
        add(0, 0, 0, 1, 0, 1,  0, W_S, W_E, 2, 1, 0);
        add(0, 0, 0, 0, 1, 1,  0, W_S, W_E, 2, 1, 0);
        add(0, 0, 0, 0, 0, 1,  1, C_S, C_E, 1, 1, 0);
        add(0, 0, 0, 1, 0, 1,  0, C_S, C_E, 1, 1, 0);
        add(0, 0, 0, 0, 1, 1,  0, C_S, C_E, 1, 1, 0);
        add(0, 0, 0, 0, 0, 1,  1, D_S, D_E, 0, 1, 0);
        add(0, 0, 0, 1, 0, 1,  0, D_S, D_E, 0, 1, 0);       // PLAY detect
        add(1, 0, 0, 0, 0, 1,  0, D_S, D_E, 1, 1, 0);       // fill 0,1,0,1 then overflow
        add(1, 1, 0, 0, 0, 1,  0, D_S, D_E, 2, 1, 0);
        add(1, 0, 0, 0, 0, 1,  0, D_S, D_E, 3, 1, 0);
        add(1, 1, 0, 0, 0, 1,  0, D_S, D_E, 4, 1, 0);
        add(1, 0, 0, 0, 0, 0,  0, D_S, D_E, 4, 1, 1);       // full: not ready, overflow
        add(0, 0, 0, 0, 1, 0,  0, D_S, D_E, 4, 1, 1);
        add(0, 0, 0, 0, 0, 0,  1, W_S, W_E, 3, 1, 1);       // drain across pointer wrap
        add(0, 0, 0, 1, 0, 1,  0, W_S, W_E, 3, 1, 1);
        add(0, 0, 0, 0, 1, 1,  0, W_S, W_E, 3, 1, 1);
        add(0, 0, 0, 0, 0, 1,  1, M_S, M_E, 2, 1, 1);
        add(0, 0, 0, 1, 0, 1,  0, M_S, M_E, 2, 1, 1);
        add(0, 0, 0, 0, 1, 1,  0, M_S, M_E, 2, 1, 1);
        add(0, 0, 0, 0, 0, 1,  1, W_S, W_E, 1, 1, 1);
        add(0, 0, 0, 1, 0, 1,  0, W_S, W_E, 1, 1, 1);
        add(0, 0, 0, 0, 1, 1,  0, W_S, W_E, 1, 1, 1);
        add(0, 0, 0, 0, 0, 1,  1, M_S, M_E, 0, 1, 1);
        add(0, 0, 0, 1, 0, 1,  0, M_S, M_E, 0, 1, 1);
        add(0, 0, 0, 0, 1, 1,  0, M_S, M_E, 0, 0, 1);       // idle, not busy
        add(1, 3, 0, 0, 0, 1,  0, M_S, M_E, 1, 1, 1);       // one queued in IDLE
        add(1, 1, 0, 0, 0, 1,  1, C_S, C_E, 1, 1, 1);       // push + pop same edge
        add(0, 0, 0, 1, 0, 1,  0, C_S, C_E, 1, 1, 1);
        add(1, 2, 0, 0, 0, 1,  0, C_S, C_E, 2, 1, 1);
        add(0, 0, 0, 0, 1, 1,  0, C_S, C_E, 2, 1, 1);
        add(0, 0, 0, 0, 0, 1,  1, M_S, M_E, 1, 1, 1);       // REQ moo
        add(1, 3, 0, 0, 0, 1,  1, M_S, M_E, 2, 1, 1);       // 2 queued in REQ
        add(1, 1, 1, 0, 0, 0,  0, M_S, M_E, 0, 0, 0);       // flush abandons request
        add(0, 0, 0, 0, 0, 1,  0, M_S, M_E, 0, 0, 0);
        add(0, 0, 0, 1, 1, 1,  0, M_S, M_E, 0, 0, 0);       // stray ack/done ignored

        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("reset");
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_reset_vals("post_reset");

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            cue_valid = vecs[i].valid; cue_id   = vecs[i].id;
            cue_flush = vecs[i].flush; play_ack = vecs[i].ack; play_done = vecs[i].done;
            #1;
            check("cue_ready", i, 32'(cue_ready), 32'(vecs[i].ready_pre));
            @(posedge clk);
            #1;
            check("play_req",    i, 32'(play_req),    32'(vecs[i].req));
            check("play_start",  i, 32'(play_start),  32'(vecs[i].st));
            check("play_end",    i, 32'(play_end),    32'(vecs[i].en));
            check("queue_count", i, 32'(queue_count), 32'(vecs[i].cnt));
            check("busy",        i, 32'(busy),        32'(vecs[i].bsy));
            check("overflow",    i, 32'(overflow),    32'(vecs[i].ovf));
        end

        // Asynchronous reset while a request is outstanding
        @(negedge clk);
        idle_inputs();
        cue_valid = 1'b1; cue_id = 2'd2;
        @(negedge clk);
        idle_inputs();
        @(posedge clk);
        #1;
        check("pre_reset_req", 0, 32'(play_req), 1);
        check("pre_reset_start", 0, 32'(play_start), 32'(D_S));
        #2;
        reset = 1'b1;
        #1;
        check_reset_vals("async_reset");
        @(negedge clk);
        reset = 1'b0;
        play_ack = 1'b1;
        @(negedge clk);
        play_ack = 1'b0;
        play_done = 1'b1;
        #1;
        check("after_ack_req",  0, 32'(play_req), 0);
        check("after_ack_busy", 0, 32'(busy), 0);
        @(negedge clk);
        idle_inputs();
        #1;
        check_reset_vals("after_done");

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end
endmodule

// File: doc/sound_cue_sequencer.md
Name: sound_cue_sequencer

Overview:
- Upstream of the clip playback stage; sits between game logic and the ROM address sequencer that drives Audio_Controller.
- Accepts sound cue events (win, moo, detect, cheer) through a ready/valid interface and queues them in a small FIFO.
- Converts each queued cue into a ROM start/end address pair and issues it to the player with a req/ack handshake, then waits for the player's done pulse before issuing the next cue.

Parameters:
- ADDR_W, 18, ROM address width.
- QDEPTH, 4, cue FIFO depth (power of 2).
- WIN_START / WIN_END, 0 / 16395, win clip bounds (inclusive).
- MOO_START / MOO_END, 16396 / 66982, moo clip bounds.
- DETECT_START / DETECT_END, 66983 / 83254, detect clip bounds.
- CHEER_START / CHEER_END, 83255 / 137138, cheer clip bounds.

Ports:
- CLOCK_50  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- cue_valid  in  1  cue offered this cycle.
- cue_id  in  2  0=win, 1=moo, 2=detect, 3=cheer.
- cue_ready  out  1  cue accepted on an edge where cue_valid&cue_ready.
- cue_flush  in  1  synchronous clear of queued (not playing) cues.
- play_req  out  1  clip request to player.
- play_start  out  ADDR_W  first sample address of requested clip.
- play_end  out  ADDR_W  last sample address of requested clip.
- play_ack  in  1  player has latched start/end.
- play_done  in  1  single-cycle pulse, clip finished.
- busy  out  1  state!=IDLE or queue non-empty.
- queue_count  out  clog2(QDEPTH)+1  entries queued.
- overflow  out  1  sticky: a cue was offered while the FIFO was full.

Behaviour:
- Reset (async): FIFO empty, state IDLE, play_req=0, play_start=play_end=0, queue_count=0, overflow=0, busy=0. cue_ready is 1 after reset.
- cue_ready = !full & !cue_flush (combinational).
- Accept: cue_valid&cue_ready at an edge pushes cue_id. Coalescing: if the queue is non-empty and cue_id equals the most recently pushed entry still queued, the cue is consumed (ready honoured) but not pushed. No coalescing against an empty queue or against the clip currently playing.
- Full: cue_valid&!cue_ready sets overflow. overflow is cleared only by reset or cue_flush.
- FSM:
  - IDLE: if queue non-empty, pop the head, load play_start/play_end from the parameter table, set play_req=1, go to REQ.
  - REQ: hold play_req, play_start and play_end stable until play_ack. On play_ack, play_req=0 and go to PLAY. play_done is ignored in REQ.
  - PLAY: on play_done, go to IDLE. play_ack is ignored.
- Latency: with an empty queue and state IDLE, a cue accepted at edge E gives queue_count=1 after E. At E+1 the head is popped (queue_count=0) and play_req=1. The next cue can issue at the edge after the play_done edge (one IDLE cycle minimum).
- Push and pop at the same edge: queue_count is unchanged; the pop takes the old head. Coalescing compares against the pre-edge tail.
- cue_flush: at the edge it is sampled, the FIFO empties, queue_count=0 and overflow=0.
  - In REQ: play_req drops, state goes to IDLE, and the request is abandoned.
  - In PLAY: the current clip continues; the FSM still waits for play_done.
  - Flush has priority over pop in IDLE.
- Pointers wrap modulo QDEPTH. queue_count range is 0..QDEPTH.
- play_start/play_end hold their last values outside REQ.
- Reset asserted mid-operation returns everything to the reset values immediately. A play_done arriving after reset is ignored in IDLE.

Test Plan:
- After reset, cue_id=1 for 1 cycle -> next cycle play_req=1, play_start=16396, play_end=66982; ack at +3 -> play_req=0; done pulse -> busy=0 after that edge.
- While PLAY, push cue ids 0,0,3,2 on consecutive cycles -> queue_count=3 (second 0 coalesced); after done, issues follow in order 0 (0/16395), 3 (83255/137138), 2 (66983/83254).
- Hold PLAY, push 5 distinct-alternating cues (0,1,0,1,0) -> 4 queued, cue_ready=0 on the 5th, overflow=1, queue_count=4; wrap verified by draining all 4 in order.
- In REQ with 2 cues queued, assert cue_flush with cue_valid=1 -> play_req=0, queue_count=0, overflow=0, cue_ready=0 that cycle, state IDLE, no further req.
- In IDLE with 1 queued entry, push a new cue the same cycle as the pop -> queue_count stays 1, the popped entry is the older cue.
- Assert reset for 1 cycle while in REQ -> all outputs return to reset values asynchronously; a play_ack/play_done arriving afterwards causes no state change.
